// File: rtl/sfifo_pkg.sv
// Shared definitions for the sfifo word packer: packer state encoding and byte width.
package sfifo_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2,
    FLUSH = 2'd3
  } state_t;

endpackage

// File: rtl/packer_out_reg.sv
// Output word register with valid/ready handshake; holds its word until accepted.
module packer_out_reg
  import sfifo_pkg::*;
#(
  parameter int WORD_BYTES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic [BYTE_W*WORD_BYTES-1:0] load_data,
  input  logic [3:0]                   load_bytes,
  input  logic                         ready,
  output logic                         can_load,
  output logic                         valid,
  output logic [BYTE_W*WORD_BYTES-1:0] data,
  output logic [3:0]                   bytes
);

  // A new word may enter when the register is empty or its word leaves this cycle.
  assign can_load = !valid || ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      bytes <= 4'd0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      bytes <= load_bytes;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_word_packer.sv
// Packs bytes read from an upstream sfifo into WORD_BYTES-wide words, flushing
// partial words on request or after FLUSH_TIMEOUT idle cycles.
module fifo_word_packer
  import sfifo_pkg::*;
#(
  parameter int WORD_BYTES    = 4,
  parameter int FLUSH_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         empty,
  output logic                         r_en,
  input  logic [7:0]                   dout,
  input  logic                         flush,
  output logic [BYTE_W*WORD_BYTES-1:0] word_data,
  output logic [3:0]                   word_bytes,
  output logic                         word_valid,
  input  logic                         word_ready
);

  localparam int         WORD_W     = BYTE_W * WORD_BYTES;
  localparam logic [3:0] FULL_CNT   = 4'(WORD_BYTES);
  localparam logic [7:0] IDLE_LIMIT = 8'(FLUSH_TIMEOUT - 1);

  state_t            state, state_next;
  logic [3:0]        cnt, cnt_next, cap_cnt;
  logic              rd_pending;
  logic [7:0]        idle_cnt, idle_next;
  logic [WORD_W-1:0] acc, acc_next, merged;
  logic              load, can_load, flush_hit, complete;

  // Reads stop once the accumulator plus the byte in flight would fill a word,
  // and while a committed word is waiting to leave.
  assign r_en = !rst && !empty && (state == IDLE || state == FILL) &&
                ((cnt + {3'b000, rd_pending}) < FULL_CNT);

  always_comb begin
    merged  = acc;
    cap_cnt = cnt;
    if (rd_pending) begin
      for (int k = 0; k < WORD_BYTES; k++) begin
        if (cnt == 4'(k)) merged[BYTE_W*k +: BYTE_W] = dout;
      end
      cap_cnt = cnt + 4'd1;
    end
  end

  assign flush_hit = (flush || (state == FILL && !rd_pending && idle_cnt == IDLE_LIMIT)) &&
                     (cap_cnt != 4'd0);

  // A finished word bypasses FULL when the output register can take it at once,
  // which keeps continuous traffic at one word per WORD_BYTES+1 cycles.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    acc_next   = acc;
    idle_next  = 8'd0;
    load       = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE, FILL: begin
        acc_next = merged;
        cnt_next = cap_cnt;
        if (cap_cnt == FULL_CNT) begin
          complete = 1'b1;
        end else if (flush_hit) begin
          if (r_en) state_next = FLUSH;
          else      complete   = 1'b1;
        end else begin
          state_next = (cap_cnt == 4'd0) ? IDLE : FILL;
          if (state == FILL && !rd_pending) idle_next = idle_cnt + 8'd1;
        end
      end
      FLUSH: begin
        acc_next = merged;
        cnt_next = cap_cnt;
        complete = 1'b1;
      end
      FULL: begin
        complete = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    if (complete) begin
      if (can_load) begin
        load       = 1'b1;
        cnt_next   = 4'd0;
        acc_next   = '0;
        state_next = IDLE;
      end else begin
        state_next = FULL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      acc        <= '0;
      idle_cnt   <= 8'd0;
      rd_pending <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      acc        <= acc_next;
      idle_cnt   <= idle_next;
      rd_pending <= r_en;
    end
  end

  packer_out_reg #(
    .WORD_BYTES(WORD_BYTES)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (merged),
    .load_bytes(cap_cnt),
    .ready     (word_ready),
    .can_load  (can_load),
    .valid     (word_valid),
    .data      (word_data),
    .bytes     (word_bytes)
  );

endmodule
